// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state type, default index width and output-width helper for decoder_stream.
package decoder_pkg;
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
   localparam int DEF_IDX_W = 2;
   function automatic int out_w(input int idx_w);
      return 1 << idx_w;
   endfunction
endpackage

// File: rtl/decoder_stream_if.sv
// decoder_stream_if: valid/ready index-in, one-hot-out bus; in_par/out_err exist only with DEC_PARITY_EN.
interface decoder_stream_if import decoder_pkg::*; #(parameter int IDX_W = DEF_IDX_W);
   logic                     in_valid;
   logic                     in_ready;
   logic [IDX_W-1:0]         in_idx;
   logic                     out_valid;
   logic                     out_ready;
   logic [out_w(IDX_W)-1:0]  out_onehot;
`ifdef DEC_PARITY_EN
   logic                     in_par;
   logic                     out_err;
   modport slave (input in_valid, in_idx, in_par, out_ready, output in_ready, out_valid, out_onehot, out_err);
   modport master (output in_valid, in_idx, in_par, out_ready, input in_ready, out_valid, out_onehot, out_err);
`else
   modport slave (input in_valid, in_idx, out_ready, output in_ready, out_valid, out_onehot);
   modport master (output in_valid, in_idx, out_ready, input in_ready, out_valid, out_onehot);
`endif
endinterface

// File: rtl/onehot_dec.sv
// onehot_dec: combinational index to one-hot decoder; with DEC_PARITY_EN an even-parity
// mismatch yields an all-zero word and err_o=1.
module onehot_dec import decoder_pkg::*; #(parameter int IDX_W = DEF_IDX_W) (
   input  logic [IDX_W-1:0]        idx_i,
`ifdef DEC_PARITY_EN
   input  logic                    par_i,
   output logic                    err_o,
`endif
   output logic [out_w(IDX_W)-1:0] onehot_o
);
   localparam int OUT_W = out_w(IDX_W);
   logic [OUT_W-1:0] dec;
   assign dec = OUT_W'(1) << idx_i;
`ifdef DEC_PARITY_EN
   assign err_o    = par_i != ^idx_i;
   assign onehot_o = err_o ? '0 : dec;
`else
   assign onehot_o = dec;
`endif
endmodule

// File: rtl/decoder_stream.sv
// decoder_stream: registered index-to-one-hot decoder with a two-entry skid buffer.
// DEC_PARITY_EN adds an even-parity check whose error bit travels with each entry.
module decoder_stream import decoder_pkg::*; #(parameter int IDX_W = DEF_IDX_W) (
   input  logic             clk,
   input  logic             rst,
   decoder_stream_if.slave  bus
);
   localparam int OUT_W = out_w(IDX_W);
`ifdef DEC_PARITY_EN
   localparam int EW = OUT_W + 1;
   logic dec_err;
`else
   localparam int EW = OUT_W;
`endif
   logic [OUT_W-1:0] dec_oh;
   logic [EW-1:0]    dec_w, main_q, main_d, skid_q, skid_d;
   state_e           state_q, state_d;
   logic             push, pop;
   onehot_dec #(.IDX_W(IDX_W)) u_dec (
      .idx_i    (bus.in_idx),
`ifdef DEC_PARITY_EN
      .par_i    (bus.in_par),
      .err_o    (dec_err),
`endif
      .onehot_o (dec_oh)
   );
`ifdef DEC_PARITY_EN
   assign dec_w       = {dec_err, dec_oh};
   assign bus.out_err = bus.out_valid && main_q[OUT_W];
`else
   assign dec_w = dec_oh;
`endif
   assign bus.in_ready   = state_q != FULL;
   assign bus.out_valid  = state_q != EMPTY;
   assign bus.out_onehot = bus.out_valid ? main_q[OUT_W-1:0] : '0;
   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: if (push) begin
            state_d = ONE;
            main_d  = dec_w;
         end
         ONE: if (push && !pop) begin
            state_d = FULL;
            skid_d  = dec_w;
         end else if (push) begin
            main_d  = dec_w;
         end else if (pop) begin
            state_d = EMPTY;
         end
         FULL: if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
         end
         default: state_d = EMPTY;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end
endmodule

// File: tb/tb_decoder_stream.sv
// tb_decoder_stream: directed and random checks of decoder_stream against a capacity-2 FIFO model.
module tb_decoder_stream;
   import decoder_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   decoder_stream_if #(.IDX_W(2)) bus ();
   decoder_stream #(.IDX_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
   int cmp = 0;
   int fails = 0;
   logic [4:0] m_q[$];
   logic e_v, e_r, e_err;
   logic [3:0] e_oh;

   function automatic logic [4:0] exp_word(input logic [1:0] idx, input logic par);
      logic err;
      err = 1'b0;
`ifdef DEC_PARITY_EN
      err = par != ^idx;
`endif
      return err ? 5'b10000 : {1'b0, 4'b0001 << idx};
   endfunction

   task automatic refresh();
      e_v = m_q.size() > 0;
      e_r = m_q.size() < 2;
      e_oh = '0;
      e_err = 1'b0;
      if (e_v) begin
         e_oh = m_q[0][3:0];
         e_err = m_q[0][4];
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] idx, input logic rdy);
      bus.in_valid = v;
      bus.in_idx = idx;
`ifdef DEC_PARITY_EN
      bus.in_par = ^idx;
`endif
      bus.out_ready = rdy;
   endtask

   task automatic tick();
      logic push, pop, par;
      par = 1'b0;
`ifdef DEC_PARITY_EN
      par = bus.in_par;
`endif
      push = bus.in_valid && m_q.size() < 2;
      pop = m_q.size() > 0 && bus.out_ready;
      @(posedge clk);
      if (rst) m_q.delete();
      else begin
         if (pop) void'(m_q.pop_front());
         if (push) m_q.push_back(exp_word(bus.in_idx, par));
      end
      @(negedge clk);
      refresh();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 2'd0, 1'b0);
      #1;
      if ({bus.out_valid, bus.in_ready, bus.out_onehot} !== 6'b010000) begin
         fails++;
         $display("FAIL reset_init: got v=%b r=%b oh=%b, need v=0 r=1 oh=0000", bus.out_valid, bus.in_ready, bus.out_onehot);
      end
      cmp++;
      tick();
      rst = 1'b0;
      drive(1'b1, 2'd2, 1'b0);
      tick();
      if ({bus.out_valid, bus.in_ready, bus.out_onehot} !== {e_v, e_r, e_oh}) begin
         fails++;
         $display("FAIL reset_prefill: got v=%b r=%b oh=%b, need v=%b r=%b oh=%b", bus.out_valid, bus.in_ready, bus.out_onehot, e_v, e_r, e_oh);
      end
      cmp++;
      rst = 1'b1;
      drive(1'b0, 2'd0, 1'b0);
      #1;
      if ({bus.out_valid, bus.in_ready, bus.out_onehot} !== 6'b010000) begin
         fails++;
         $display("FAIL reset_mid: got v=%b r=%b oh=%b, need v=0 r=1 oh=0000", bus.out_valid, bus.in_ready, bus.out_onehot);
      end
      cmp++;
      m_q.delete();
      tick();
      rst = 1'b0;
      drive(1'b0, 2'd0, 1'b1);
      tick();
      if ({bus.out_valid, bus.in_ready, bus.out_onehot} !== 6'b010000) begin
         fails++;
         $display("FAIL reset_after: got v=%b r=%b oh=%b, need v=0 r=1 oh=0000", bus.out_valid, bus.in_ready, bus.out_onehot);
      end
      cmp++;
   endtask

   task automatic test_stream();
      logic [3:0] want;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2'(i), 1'b1);
         tick();
         want = 4'b0001 << i;
         if ({bus.out_valid, bus.in_ready, bus.out_onehot} !== {2'b11, want} || bus.out_onehot !== e_oh) begin
            fails++;
            $display("FAIL stream[%0d]: got v=%b r=%b oh=%b, need v=1 r=1 oh=%b", i, bus.out_valid, bus.in_ready, bus.out_onehot, want);
         end
         cmp++;
      end
      drive(1'b0, 2'd0, 1'b1);
      tick();
      if ({bus.out_valid, bus.out_onehot} !== {e_v, e_oh}) begin
         fails++;
         $display("FAIL stream_drain: got v=%b oh=%b, need v=%b oh=%b", bus.out_valid, bus.out_onehot, e_v, e_oh);
      end
      cmp++;
   endtask

   task automatic test_backpressure();
      drive(1'b1, 2'd2, 1'b0);
      tick();
      drive(1'b1, 2'd3, 1'b0);
      tick();
      for (int i = 0; i < 2; i++) begin
         if ({bus.out_valid, bus.in_ready, bus.out_onehot} !== 6'b100100) begin
            fails++;
            $display("FAIL bp_full[%0d]: got v=%b r=%b oh=%b, need v=1 r=0 oh=0100", i, bus.out_valid, bus.in_ready, bus.out_onehot);
         end
         cmp++;
         drive(1'b1, 2'd1, 1'b0);
         tick();
      end
      drive(1'b0, 2'd0, 1'b1);
      tick();
      if ({bus.out_valid, bus.in_ready, bus.out_onehot} !== 6'b111000) begin
         fails++;
         $display("FAIL bp_second: got v=%b r=%b oh=%b, need v=1 r=1 oh=1000", bus.out_valid, bus.in_ready, bus.out_onehot);
      end
      cmp++;
      tick();
      if (bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_empty: got v=%b, need v=0", bus.out_valid);
      end
      cmp++;
   endtask

   task automatic test_push_pop_one();
      drive(1'b1, 2'd1, 1'b1);
      tick();
      drive(1'b1, 2'd0, 1'b1);
      tick();
      if ({bus.out_valid, bus.in_ready, bus.out_onehot} !== 6'b110001) begin
         fails++;
         $display("FAIL push_pop_one: got v=%b r=%b oh=%b, need v=1 r=1 oh=0001", bus.out_valid, bus.in_ready, bus.out_onehot);
      end
      cmp++;
      drive(1'b0, 2'd0, 1'b1);
      tick();
   endtask

`ifdef DEC_PARITY_EN
   task automatic test_parity();
      drive(1'b1, 2'd3, 1'b1);
      bus.in_par = 1'b1;
      tick();
      if ({bus.out_valid, bus.out_err, bus.out_onehot} !== 6'b110000) begin
         fails++;
         $display("FAIL parity_bad: got v=%b err=%b oh=%b, need v=1 err=1 oh=0000", bus.out_valid, bus.out_err, bus.out_onehot);
      end
      cmp++;
      bus.in_par = 1'b0;
      tick();
      if ({bus.out_valid, bus.out_err, bus.out_onehot} !== 6'b101000) begin
         fails++;
         $display("FAIL parity_good: got v=%b err=%b oh=%b, need v=1 err=0 oh=1000", bus.out_valid, bus.out_err, bus.out_onehot);
      end
      cmp++;
      drive(1'b0, 2'd0, 1'b1);
      tick();
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0));
`ifdef DEC_PARITY_EN
         if ($urandom_range(0, 3) == 0) bus.in_par = ~bus.in_par;
`endif
         tick();
         if ({bus.out_valid, bus.in_ready, bus.out_onehot} !== {e_v, e_r, e_oh}) begin
            fails++;
            $display("FAIL random[%0d]: got v=%b r=%b oh=%b, need v=%b r=%b oh=%b", i, bus.out_valid, bus.in_ready, bus.out_onehot, e_v, e_r, e_oh);
         end
         cmp++;
`ifdef DEC_PARITY_EN
         if (bus.out_err !== e_err) begin
            fails++;
            $display("FAIL random_err[%0d]: got err=%b, need err=%b", i, bus.out_err, e_err);
         end
         cmp++;
`endif
      end
      drive(1'b0, 2'd0, 1'b1);
      tick();
      tick();
   endtask

   task automatic test_reset_full();
      drive(1'b1, 2'd2, 1'b0);
      tick();
      drive(1'b1, 2'd3, 1'b0);
      tick();
      if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
         fails++;
         $display("FAIL rf_full: got v=%b r=%b, need v=1 r=0", bus.out_valid, bus.in_ready);
      end
      cmp++;
      #2 rst = 1'b1;
      #1;
      if ({bus.out_valid, bus.in_ready, bus.out_onehot} !== 6'b010000) begin
         fails++;
         $display("FAIL rf_async: got v=%b r=%b oh=%b, need v=0 r=1 oh=0000", bus.out_valid, bus.in_ready, bus.out_onehot);
      end
      cmp++;
      m_q.delete();
      rst = 1'b0;
      drive(1'b1, 2'd1, 1'b1);
      tick();
      if ({bus.out_valid, bus.in_ready, bus.out_onehot} !== 6'b110010) begin
         fails++;
         $display("FAIL rf_next: got v=%b r=%b oh=%b, need v=1 r=1 oh=0010", bus.out_valid, bus.in_ready, bus.out_onehot);
      end
      cmp++;
      drive(1'b0, 2'd0, 1'b1);
      tick();
      if ({bus.out_valid, bus.out_onehot} !== 5'b00000) begin
         fails++;
         $display("FAIL rf_only: got v=%b oh=%b, need v=0 oh=0000", bus.out_valid, bus.out_onehot);
      end
      cmp++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_push_pop_one();
`ifdef DEC_PARITY_EN
      test_parity();
`endif
      test_random();
      test_reset_full();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
      $finish;
   end
endmodule
